// File: rtl/dct8_stream.sv
// dct8_stream: pipelined 8-point DCT-II (forward) / DCT-III (inverse) engine.
// Three stages under one advance enable: input capture, 64 products, adder trees + rounding.
module dct8_stream #(
  parameter int W_I       = 8,
  parameter int W_COEF    = 13,
  parameter int W_O       = W_I + W_COEF + 2,
  parameter int OUT_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*W_I-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [8*W_O-1:0]   out_data
);

  localparam int W_P = W_I + W_COEF;
  localparam int W_S = W_P + 3;
  localparam int RND = (1 << OUT_SHIFT) >> 1;

  // cos(m*pi/16) scaled by 2^30 for m = 0..8; other angles fold onto this quadrant.
  function automatic longint cos_tab(input int m);
    longint r;
    case (m)
      0:       r = 1073741824;
      1:       r = 1053110176;
      2:       r = 992008095;
      3:       r = 892783698;
      4:       r = 759250125;
      5:       r = 596538995;
      6:       r = 410903207;
      7:       r = 209476638;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Round-half-away-from-zero of 2^(W_COEF-1) * 0.5 * ck * cos((2n+1)k*pi/16).
  function automatic int coef(input int k, input int n);
    int     m;
    longint mag;
    longint c;
    bit     neg;
    m = ((2 * n + 1) * k) % 32;
    neg = 1'b0;
    if (k == 0) begin
      mag = cos_tab(4);
    end else if (m <= 8) begin
      mag = cos_tab(m);
    end else if (m <= 16) begin
      mag = cos_tab(16 - m);
      neg = 1'b1;
    end else if (m <= 24) begin
      mag = cos_tab(m - 16);
      neg = 1'b1;
    end else begin
      mag = cos_tab(32 - m);
    end
    c = ((mag << (W_COEF - 2)) + (64'sd1 << 29)) >>> 30;
    return neg ? -int'(c) : int'(c);
  endfunction

  logic                    adv;
  logic                    s1_valid_q, s1_inv_q;
  logic [8*W_I-1:0]        s1_data_q;
  logic                    s2_valid_q, s2_inv_q;
  logic signed [W_P-1:0]   prod_d  [8][8];
  logic signed [W_P-1:0]   s2_prod_q [8][8];
  logic signed [W_S-1:0]   acc     [8];
  logic [8*W_O-1:0]        res_d;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // prod_d[o][j] is the contribution of sample j to result o; inverse uses the transpose.
  for (genvar o = 0; o < 8; o++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      localparam logic signed [W_COEF-1:0] CoefFwd = W_COEF'(coef(o, j));
      localparam logic signed [W_COEF-1:0] CoefInv = W_COEF'(coef(j, o));
      logic signed [W_COEF-1:0] coef_sel;
      assign coef_sel = s1_inv_q ? CoefInv : CoefFwd;
      assign prod_d[o][j] = W_P'(coef_sel) * W_P'($signed(s1_data_q[j*W_I +: W_I]));
    end
  end

  always_comb begin
    acc   = '{default: '0};
    res_d = '0;
    for (int o = 0; o < 8; o++) begin
      for (int j = 0; j < 8; j++) begin
        acc[o] = acc[o] + W_S'(s2_prod_q[o][j]);
      end
      res_d[o*W_O +: W_O] = W_O'((acc[o] + W_S'(RND)) >>> OUT_SHIFT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_prod_q  <= '{default: '0};
      out_valid  <= 1'b0;
      out_inv    <= 1'b0;
      out_data   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      out_valid  <= s2_valid_q;
      // Payloads only move with a valid beat, so bubbles leave stale data harmlessly behind.
      if (in_valid) begin
        s1_inv_q  <= in_inv;
        s1_data_q <= in_data;
      end
      if (s1_valid_q) begin
        s2_inv_q  <= s1_inv_q;
        s2_prod_q <= prod_d;
      end
      if (s2_valid_q) begin
        out_inv  <= s2_inv_q;
        out_data <= res_d;
      end
    end
  end

endmodule

// File: doc/dct8_stream.md
Name: dct8_stream

Overview:
- Parametrised, pipelined 8-point 1-D DCT-II engine. Selectable inverse (DCT-III) mode per beat and optional rounded output scaling.
- Accepts one 8-sample vector per cycle under a valid/ready handshake. Emits one 8-coefficient vector per cycle after a fixed latency.
- Successor to the current fixed-width 8-point dct core. Serves as the row/column engine for the planned 8x8 2-D transform.

Parameters:
- W_I, 8, signed input sample width.
- W_COEF, 13, signed coefficient width (Q1.(W_COEF-1)).
- W_O, W_I+W_COEF+2, signed output width; must be >= W_I+W_COEF+2.
- OUT_SHIFT, 0, right-shift applied to each result with round-half-up; 0 = full precision.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input vector valid.
- in_ready, output, 1, engine can accept a vector this cycle.
- in_inv, input, 1, 0 = forward DCT, 1 = inverse; qualified by the beat.
- in_data, input, 8*W_I, samples f0..f7, f0 in bits [W_I-1:0].
- out_valid, output, 1, output vector valid.
- out_ready, input, 1, downstream accepts the vector.
- out_inv, output, 1, mode of the beat currently on out_data.
- out_data, output, 8*W_O, results F0..F7, F0 in bits [W_O-1:0].

Behaviour:
- Coefficients are computed at elaboration: C(k,n) = round(2^(W_COEF-1) * 0.5 * ck * cos((2n+1)k*pi/16)), where ck = 1/sqrt(2) for k=0 and 1 otherwise. Rounding is half away from zero.
- For W_COEF=13, row n=0 of C is 1448, 2009, 1892, 1703, 1448, 1138, 784, 400 for k=0..7.
- Forward: F[k] = sum over n of C(k,n)*f[n]. Inverse: F[n] = sum over k of C(k,n)*f[k] (transposed matrix).
- All arithmetic is signed. Products are W_I+W_COEF bits; the 8-term sum is W_I+W_COEF+3 bits internally, then sign-extended or truncated to W_O.
- Scaling: if OUT_SHIFT > 0, result = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic). No saturation.
- Pipeline has 3 register stages:
  - S1 captures in_data and in_inv.
  - S2 holds the 64 products.
  - S3 holds the adder trees, rounding and the output register.
- Latency is exactly 3 cycles from the accepting edge (in_valid & in_ready) to out_valid, when not stalled.
- Each stage carries a valid bit. Global advance enable: adv = ~out_valid | out_ready. in_ready = adv, which is combinational from out_ready.
- When adv=0, all stages hold. out_data and out_inv stay stable while out_valid & ~out_ready.
- Bubbles propagate: a stage with valid=0 loads the upstream contents when adv=1. No compaction of bubbles while stalled.
- Throughput is 1 vector per cycle when out_ready is held at 1.
- in_valid=0 inserts a bubble. in_data and in_inv are ignored when not accepted.
- Mode travels with its beat, so forward and inverse beats may alternate back-to-back with no drain.
- Reset values (asynchronous, on reset_n low): all stage valid bits 0, out_valid=0, out_data=0, out_inv=0. in_ready reads 1 during and after reset.
- Reset mid-operation discards all in-flight vectors. The first vector accepted after release appears 3 cycles later.
- Simultaneous in accept and out handshake in one cycle is legal and required for full throughput.
- No internal state beyond the pipeline: no counters or RAM. Vectors emerge in order, one out per one in.

Test Plan:
- Forward impulse, W_COEF=13, OUT_SHIFT=0: f=(1,0,0,0,0,0,0,0) -> F=(1448,2009,1892,1703,1448,1138,784,400), out_valid exactly 3 cycles after accept, out_inv=0.
- Forward DC plus step, back-to-back: f=all 1s, then f=(5,5,5,5,0,0,0,0) on consecutive cycles with out_ready=1 -> F=(11584,0,0,0,0,0,0,0), then F0=28960 and F1=26250, on consecutive cycles.
- Inverse mode: in_inv=1, f=(1,0,0,0,0,0,0,0) -> all eight outputs 1448, out_inv=1. Alternating inv/fwd beats are each correct.
- Scaling build OUT_SHIFT=12: all-1s gives F0=3. f=(-1,0,...) gives F0=0 and F1=0 (round-half-up of -1448 and -2009).
- Backpressure: 5 vectors streamed, out_ready low for 4 cycles mid-stream -> in_ready low during the stall, out_data stable, no loss or duplication, order preserved.
- Async reset: assert reset_n=0 with 2 vectors in flight -> out_valid drops immediately, out_data=0. A vector sent after release yields correct output at latency 3.
